// File: rtl/vip_flow_frame_sequencer.sv
// ---------------------------------------------------------------------------
// vip_flow_frame_sequencer
//
// Frame-level controller for the VIP stall/read/write flow-control wrapper.
// It latches frame dimensions from a decoder control packet and asks the
// encoder to send its own control packet. It then issues `read` for exactly
// width*height input pixels and produces `write` LATENCY enabled cycles
// later, matching the fixed-latency algorithm pipeline. The final output
// pixel of a frame is tagged with end_of_video_out.
//
// Optional build macro: FLOW_SEQ_STATS_EN adds frame_count / trunc_count.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enable            allows a new frame to start from IDLE
//   vip_ctrl_valid    decoder control-packet fields valid
//   width_in, height_in, interlaced_in   decoder frame fields
//   end_of_video      decoder end-of-video, qualified by read
//   stall_in          no input pixel available
//   stall_out         encoder not ready (freezes the pipeline)
//   vip_ctrl_busy     encoder busy sending its control packet
//   read              consume one input pixel this cycle
//   write             output pixel valid
//   vip_ctrl_send     encoder control-packet request (one cycle)
//   width_out, height_out, interlaced_out   latched frame fields
//   end_of_video_out  high with the final write of a frame
//   busy              sequencer is not idle
//   frame_done        one-cycle pulse at frame completion
//   truncated         sticky: last frame ended early on end_of_video
//   frame_count       (FLOW_SEQ_STATS_EN) frames completed, wrapping
//   trunc_count       (FLOW_SEQ_STATS_EN) truncated frames, saturating
//
// Handshake: `read` means one pixel is consumed in the cycle it is high;
// `write` means one pixel is presented and is accepted only when stall_out
// is low -- while stall_out is high `write` holds the same pixel.
// ---------------------------------------------------------------------------
module vip_flow_frame_sequencer #(
  parameter int LATENCY = 2,
  parameter int MAX_DIM = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        vip_ctrl_valid,
  input  logic [15:0] width_in,
  input  logic [15:0] height_in,
  input  logic [3:0]  interlaced_in,
  input  logic        end_of_video,
  input  logic        stall_in,
  input  logic        stall_out,
  input  logic        vip_ctrl_busy,
  output logic        read,
  output logic        write,
  output logic        vip_ctrl_send,
  output logic [15:0] width_out,
  output logic [15:0] height_out,
  output logic [3:0]  interlaced_out,
  output logic        end_of_video_out,
  output logic        busy,
  output logic        frame_done,
  output logic        truncated
`ifdef FLOW_SEQ_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] trunc_count
`endif
);

  localparam logic [15:0] MAX_DIM_L = 16'(MAX_DIM);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_ACK = 3'd2,
    PROCESS  = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t state, state_next;

  logic [15:0]        x_cnt, y_cnt;
  logic [LATENCY-1:0] valid_sr, last_sr;
  logic               pe;
  logic               start;
  logic               is_last;
  logic               tag_last;
  logic [15:0]        width_clamped, height_clamped;

  assign pe    = ~stall_out;
  assign start = enable & vip_ctrl_valid & ~vip_ctrl_busy;

  assign width_clamped  = (width_in  > MAX_DIM_L) ? MAX_DIM_L : width_in;
  assign height_clamped = (height_in > MAX_DIM_L) ? MAX_DIM_L : height_in;

  // Counters run 0..dim-1, so comparing against dim-1 never overflows.
  assign is_last  = (x_cnt == width_out - 16'd1) && (y_cnt == height_out - 16'd1);
  assign tag_last = read & (is_last | end_of_video);

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------
  // FSM next-state and combinational outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    read          = 1'b0;
    vip_ctrl_send = 1'b0;
    frame_done    = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_next = SEND;
      end
      SEND: begin
        vip_ctrl_send = 1'b1;
        state_next    = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Entering this state guarantees at least one cycle here.
        if (!vip_ctrl_busy) begin
          if (width_out == 16'd0 || height_out == 16'd0) state_next = DONE;
          else                                            state_next = PROCESS;
        end
      end
      PROCESS: begin
        read = ~stall_in & pe;
        if (tag_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (pe & valid_sr[LATENCY-1] & last_sr[LATENCY-1]) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame fields, pixel counters and truncation flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_out      <= '0;
      height_out     <= '0;
      interlaced_out <= '0;
      truncated      <= 1'b0;
      x_cnt          <= '0;
      y_cnt          <= '0;
    end else begin
      if (state == IDLE && start) begin
        width_out      <= width_clamped;
        height_out     <= height_clamped;
        interlaced_out <= interlaced_in;
        truncated      <= 1'b0;
        x_cnt          <= '0;
        y_cnt          <= '0;
      end else if (state == PROCESS && read) begin
        if (x_cnt == width_out - 16'd1) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 16'd1;
        end else begin
          x_cnt <= x_cnt + 16'd1;
        end
        // end_of_video on the genuine last pixel is not a truncation.
        if (end_of_video && !is_last) truncated <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Valid / last-tag pipeline mirroring the algorithm latency
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else if (pe) begin
      valid_sr[0] <= read;
      last_sr[0]  <= tag_last;
      for (int i = 1; i < LATENCY; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
      end
    end
  end

  assign write            = valid_sr[LATENCY-1];
  assign end_of_video_out = valid_sr[LATENCY-1] & last_sr[LATENCY-1];

`ifdef FLOW_SEQ_STATS_EN
  // ---------------------------------------------------------------------
  // Frame statistics
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
      trunc_count <= '0;
    end else if (state == DONE) begin
      frame_count <= frame_count + 16'd1;
      if (truncated && trunc_count != 16'hFFFF) trunc_count <= trunc_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vip_flow_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vip_flow_frame_sequencer
//
// Directed bench for vip_flow_frame_sequencer with LATENCY=2. Inputs are
// driven on the falling edge, outputs sampled 1ns later. Cycle numbers in
// the expectations count falling edges from the one where vip_ctrl_valid is
// presented (c=0): SEND at c=1, WAIT_ACK at c=2, first read at c=3 when the
// encoder is not busy, first write two enabled cycles after the first read.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vip_flow_frame_sequencer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        vip_ctrl_valid;
  logic [15:0] width_in;
  logic [15:0] height_in;
  logic [3:0]  interlaced_in;
  logic        end_of_video;
  logic        stall_in;
  logic        stall_out;
  logic        vip_ctrl_busy;
  logic        read;
  logic        write;
  logic        vip_ctrl_send;
  logic [15:0] width_out;
  logic [15:0] height_out;
  logic [3:0]  interlaced_out;
  logic        end_of_video_out;
  logic        busy;
  logic        frame_done;
  logic        truncated;
`ifdef FLOW_SEQ_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] trunc_count;
`endif

  int n_compared;
  int n_mismatched;

  // Per-frame observations filled in by run_frame
  int send_cnt, send_cyc;
  int read_cnt, first_read_cyc;
  int write_cnt, first_write_cyc;
  int eov_write_idx, eov_cnt;
  int done_cyc;
  int violations;
  logic trunc_at_done;

  vip_flow_frame_sequencer #(.LATENCY(2), .MAX_DIM(4096)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .vip_ctrl_valid   (vip_ctrl_valid),
    .width_in         (width_in),
    .height_in        (height_in),
    .interlaced_in    (interlaced_in),
    .end_of_video     (end_of_video),
    .stall_in         (stall_in),
    .stall_out        (stall_out),
    .vip_ctrl_busy    (vip_ctrl_busy),
    .read             (read),
    .write            (write),
    .vip_ctrl_send    (vip_ctrl_send),
    .width_out        (width_out),
    .height_out       (height_out),
    .interlaced_out   (interlaced_out),
    .end_of_video_out (end_of_video_out),
    .busy             (busy),
    .frame_done       (frame_done),
    .truncated        (truncated)
`ifdef FLOW_SEQ_STATS_EN
    ,
    .frame_count      (frame_count),
    .trunc_count      (trunc_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Driver: runs one frame and records what the DUT did.
  //   eov_at     : 1-based read index carrying end_of_video (0 = none)
  //   stall_beg  : first cycle of a stall_out window, stall_len cycles long
  //   busy_len   : cycles vip_ctrl_busy stays high after the SEND cycle
  // -------------------------------------------------------------------------
  task automatic run_frame(input logic [15:0] w, input logic [15:0] h,
                           input logic [3:0] il, input int eov_at,
                           input int stall_beg, input int stall_len,
                           input int busy_len);
    logic prev_write;
    logic prev_stall;
    bit   finished;
    send_cnt = 0; send_cyc = -1;
    read_cnt = 0; first_read_cyc = -1;
    write_cnt = 0; first_write_cyc = -1;
    eov_write_idx = -1; eov_cnt = 0;
    done_cyc = -1; violations = 0; trunc_at_done = 1'b0;
    prev_write = 1'b0; prev_stall = 1'b0;
    finished = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      @(negedge clk);
      enable         = 1'b1;
      vip_ctrl_valid = (c == 0);
      width_in       = w;
      height_in      = h;
      interlaced_in  = il;
      stall_out      = (c >= stall_beg) && (c < stall_beg + stall_len);
      vip_ctrl_busy  = (send_cyc >= 0) && (c > send_cyc) && (c <= send_cyc + busy_len);
      end_of_video   = (eov_at != 0) && (read_cnt + 1 == eov_at);
      #1;
      if (vip_ctrl_send) begin
        send_cnt++;
        send_cyc = c;
      end
      if (read) begin
        if (first_read_cyc < 0) first_read_cyc = c;
        read_cnt++;
        if (stall_out || vip_ctrl_busy) violations++;
      end
      if (stall_out && prev_stall && (write !== prev_write)) violations++;
      if (write && !stall_out) begin
        if (first_write_cyc < 0) first_write_cyc = c;
        write_cnt++;
        if (end_of_video_out) begin
          eov_cnt++;
          eov_write_idx = write_cnt;
        end
      end
      if (frame_done) begin
        done_cyc = c;
        trunc_at_done = truncated;
        finished = 1'b1;
      end
      prev_write = write;
      prev_stall = stall_out;
    end
    enable         = 1'b0;
    vip_ctrl_valid = 1'b0;
    stall_out      = 1'b0;
    vip_ctrl_busy  = 1'b0;
    end_of_video   = 1'b0;
    n_compared++;
    if (!finished) begin
      n_mismatched++;
      $display("FAIL frame_timeout: no frame_done within 300 cycles (w=%0d h=%0d)", w, h);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenario tasks
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0; vip_ctrl_valid = 1'b0; width_in = '0; height_in = '0;
    interlaced_in = '0; end_of_video = 1'b0; stall_in = 1'b0;
    stall_out = 1'b0; vip_ctrl_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_compared++;
    if ({read, write, vip_ctrl_send, end_of_video_out, busy, frame_done, truncated} !== 7'b0) begin
      n_mismatched++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {read, write, vip_ctrl_send, end_of_video_out, busy, frame_done, truncated});
    end
    n_compared++;
    if ({width_out, height_out, interlaced_out} !== 36'd0) begin
      n_mismatched++;
      $display("FAIL reset_fields: got w=%0d h=%0d i=%0d expected 0", width_out, height_out, interlaced_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_4x2();
    run_frame(16'd4, 16'd2, 4'd5, 0, 1000, 0, 0);
    n_compared++;
    if (send_cnt !== 1 || send_cyc !== 1) begin
      n_mismatched++;
      $display("FAIL basic_send: got cnt=%0d cyc=%0d expected cnt=1 cyc=1", send_cnt, send_cyc);
    end
    n_compared++;
    if (read_cnt !== 8 || first_read_cyc !== 3) begin
      n_mismatched++;
      $display("FAIL basic_reads: got cnt=%0d first=%0d expected 8 / 3", read_cnt, first_read_cyc);
    end
    n_compared++;
    if (write_cnt !== 8 || first_write_cyc !== 5) begin
      n_mismatched++;
      $display("FAIL basic_writes: got cnt=%0d first=%0d expected 8 / 5", write_cnt, first_write_cyc);
    end
    n_compared++;
    if (eov_cnt !== 1 || eov_write_idx !== 8) begin
      n_mismatched++;
      $display("FAIL basic_eov: got cnt=%0d idx=%0d expected 1 / 8", eov_cnt, eov_write_idx);
    end
    n_compared++;
    if (done_cyc !== 13 || trunc_at_done !== 1'b0) begin
      n_mismatched++;
      $display("FAIL basic_done: got cyc=%0d trunc=%b expected 13 / 0", done_cyc, trunc_at_done);
    end
    n_compared++;
    if (width_out !== 16'd4 || height_out !== 16'd2 || interlaced_out !== 4'd5) begin
      n_mismatched++;
      $display("FAIL basic_fields: got %0d/%0d/%0d expected 4/2/5", width_out, height_out, interlaced_out);
    end
  endtask

  task automatic test_stall_out_3x3();
    run_frame(16'd3, 16'd3, 4'd0, 0, 5, 5, 0);
    n_compared++;
    if (violations !== 0) begin
      n_mismatched++;
      $display("FAIL stall_hold: got %0d violations expected 0", violations);
    end
    n_compared++;
    if (read_cnt !== 9 || write_cnt !== 9) begin
      n_mismatched++;
      $display("FAIL stall_counts: got reads=%0d writes=%0d expected 9 / 9", read_cnt, write_cnt);
    end
    n_compared++;
    if (done_cyc !== 19 || eov_write_idx !== 9) begin
      n_mismatched++;
      $display("FAIL stall_done: got cyc=%0d eov_idx=%0d expected 19 / 9", done_cyc, eov_write_idx);
    end
  endtask

  task automatic test_early_eov_4x4();
    run_frame(16'd4, 16'd4, 4'd0, 6, 1000, 0, 0);
    n_compared++;
    if (read_cnt !== 6 || write_cnt !== 6) begin
      n_mismatched++;
      $display("FAIL early_eov_counts: got reads=%0d writes=%0d expected 6 / 6", read_cnt, write_cnt);
    end
    n_compared++;
    if (eov_cnt !== 1 || eov_write_idx !== 6) begin
      n_mismatched++;
      $display("FAIL early_eov_tag: got cnt=%0d idx=%0d expected 1 / 6", eov_cnt, eov_write_idx);
    end
    n_compared++;
    if (trunc_at_done !== 1'b1 || done_cyc !== 11) begin
      n_mismatched++;
      $display("FAIL early_eov_trunc: got trunc=%b cyc=%0d expected 1 / 11", trunc_at_done, done_cyc);
    end
  endtask

  task automatic test_zero_width();
    // Width clamp is checked here too: 5000 latches as 4096.
    run_frame(16'd0, 16'd7, 4'd3, 0, 1000, 0, 0);
    n_compared++;
    if (send_cnt !== 1 || read_cnt !== 0 || write_cnt !== 0 || done_cyc !== 3) begin
      n_mismatched++;
      $display("FAIL zero_width: got send=%0d reads=%0d writes=%0d done=%0d expected 1/0/0/3",
               send_cnt, read_cnt, write_cnt, done_cyc);
    end
    n_compared++;
    if (trunc_at_done !== 1'b0) begin
      n_mismatched++;
      $display("FAIL trunc_cleared: got %b expected 0", trunc_at_done);
    end
    run_frame(16'd5000, 16'd0, 4'd9, 0, 1000, 0, 0);
    n_compared++;
    if (width_out !== 16'd4096 || height_out !== 16'd0 || interlaced_out !== 4'd9 || done_cyc !== 3) begin
      n_mismatched++;
      $display("FAIL clamp: got w=%0d h=%0d i=%0d done=%0d expected 4096/0/9/3",
               width_out, height_out, interlaced_out, done_cyc);
    end
  endtask

  task automatic test_ctrl_busy();
    // busy high for c=2..11; WAIT_ACK leaves at c=12, first read c=13.
    run_frame(16'd2, 16'd1, 4'd0, 0, 1000, 0, 10);
    n_compared++;
    if (first_read_cyc !== 13 || violations !== 0) begin
      n_mismatched++;
      $display("FAIL ctrl_busy_wait: got first_read=%0d violations=%0d expected 13 / 0",
               first_read_cyc, violations);
    end
    n_compared++;
    if (read_cnt !== 2 || write_cnt !== 2 || done_cyc !== 17) begin
      n_mismatched++;
      $display("FAIL ctrl_busy_frame: got reads=%0d writes=%0d done=%0d expected 2/2/17",
               read_cnt, write_cnt, done_cyc);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      enable = 1'b1;
      vip_ctrl_valid = (c == 0);
      width_in = 16'd4; height_in = 16'd4; interlaced_in = 4'd2;
    end
    #1;
    n_compared++;
    if (read !== 1'b1 || busy !== 1'b1 || write !== 1'b1) begin
      n_mismatched++;
      $display("FAIL mid_reset_pre: got read=%b busy=%b write=%b expected 1/1/1", read, busy, write);
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    n_compared++;
    if ({read, write, vip_ctrl_send, end_of_video_out, busy, frame_done, truncated} !== 7'b0 ||
        {width_out, height_out, interlaced_out} !== 36'd0) begin
      n_mismatched++;
      $display("FAIL mid_reset_post: got ctrl=%b w=%0d h=%0d i=%0d expected all 0",
               {read, write, vip_ctrl_send, end_of_video_out, busy, frame_done, truncated},
               width_out, height_out, interlaced_out);
    end
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    vip_ctrl_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    // After an aborted frame no stale pixels may appear.
    for (int f = 0; f < 2; f++) begin
      run_frame(16'd2, 16'd2, 4'd0, 0, 1000, 0, 0);
      n_compared++;
      if (read_cnt !== 4 || write_cnt !== 4 || first_write_cyc !== 5 || done_cyc !== 9) begin
        n_mismatched++;
        $display("FAIL back_to_back_%0d: got reads=%0d writes=%0d first_write=%0d done=%0d expected 4/4/5/9",
                 f, read_cnt, write_cnt, first_write_cyc, done_cyc);
      end
    end
  endtask

`ifdef FLOW_SEQ_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_frame(16'd2, 16'd1, 4'd0, 0, 1000, 0, 0);
    run_frame(16'd2, 16'd2, 4'd0, 2, 1000, 0, 0);
    run_frame(16'd2, 16'd1, 4'd0, 0, 1000, 0, 0);
    @(negedge clk);
    #1;
    n_compared++;
    if (frame_count !== 16'd3 || trunc_count !== 16'd1) begin
      n_mismatched++;
      $display("FAIL stats: got frames=%0d truncs=%0d expected 3 / 1", frame_count, trunc_count);
    end
  endtask
`endif

  // -------------------------------------------------------------------------
  // Sequence and final report
  // -------------------------------------------------------------------------
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_basic_4x2();
    test_stall_out_3x3();
    test_early_eov_4x4();
    test_zero_width();
    test_ctrl_busy();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef FLOW_SEQ_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
